// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store controller between the memory stage and data_memory
module load_store_unit #(
  parameter int DMEM_DATA_WIDTH = 32,
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_store,
  input  logic [2:0]                 req_funct3,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [DMEM_DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]                 req_rd,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DMEM_DATA_WIDTH-1:0] resp_data,
  output logic [4:0]                 resp_rd,
  output logic                       resp_misaligned,
  output logic                       resp_illegal,
  output logic                       dmem_wr_en,
  output logic [1:0]                 dmem_rw_mode,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DMEM_DATA_WIDTH-1:0] dmem_w_data,
  input  logic [DMEM_DATA_WIDTH-1:0] dmem_r_data
);
  localparam int W = DMEM_DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  state_t state, state_n;
  logic store_q;
  logic [2:0] f3_q;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q;
  logic [W-1:0] wdata_q, r_byte, r_half, load_ext, w_byte, w_half;
  logic accept, illegal, misaligned, mem_act;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept = req_valid & req_ready;
  assign illegal = req_store ? req_funct3 > 3'd2 : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
  assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign mem_act = state == ACCESS || state == CAPTURE;
  assign dmem_addr = mem_act ? addr_q : '0;
  assign dmem_rw_mode = mem_act ? (f3_q[1] ? 2'b00 : f3_q[0] ? 2'b01 : 2'b10) : 2'b00;
  assign dmem_wr_en = state == ACCESS && store_q;
  assign w_byte = W'(wdata_q[7:0]);
  assign w_half = W'(wdata_q[15:0]);
  assign dmem_w_data = !dmem_wr_en ? '0 : f3_q[1] ? wdata_q : f3_q[0] ? w_half : w_byte;
  assign r_byte = f3_q[2] ? W'(dmem_r_data[7:0]) : W'($signed(dmem_r_data[7:0]));
  assign r_half = f3_q[2] ? W'(dmem_r_data[15:0]) : W'($signed(dmem_r_data[15:0]));
  assign load_ext = f3_q[1] ? dmem_r_data : f3_q[0] ? r_half : r_byte;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: faults skip the memory, stores skip capture
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? ((illegal || misaligned) ? RESP : ACCESS) : IDLE;
      ACCESS:  state_n = store_q ? RESP : CAPTURE;
      CAPTURE: state_n = RESP;
      RESP:    state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // request capture at accept, load data capture after the memory read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      store_q         <= 1'b0;
      f3_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      resp_data       <= '0;
      resp_rd         <= '0;
      resp_illegal    <= 1'b0;
      resp_misaligned <= 1'b0;
    end else if (accept) begin
      store_q         <= req_store;
      f3_q            <= req_funct3;
      addr_q          <= req_addr;
      wdata_q         <= req_wdata;
      resp_data       <= '0;
      resp_rd         <= req_rd;
      resp_illegal    <= illegal;
      resp_misaligned <= !illegal && misaligned;
    end else if (state == CAPTURE) resp_data <= load_ext;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven checks of load_store_unit against a byte-array memory model
module tb_load_store_unit;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_store = 0, resp_valid, resp_ready = 0;
  logic [2:0] req_funct3 = 0;
  logic [11:0] req_addr = 0, dmem_addr;
  logic [31:0] req_wdata = 0, resp_data, dmem_w_data, dmem_r_data;
  logic [4:0] req_rd = 0, resp_rd;
  logic resp_misaligned, resp_illegal, dmem_wr_en;
  logic [1:0] dmem_rw_mode;
  logic [7:0] mem [4096];
  int checks = 0, errors = 0, cur = -1;

  typedef struct {
    logic st; logic [2:0] f3; logic [11:0] addr; logic [31:0] wd; logic [4:0] rd;
    logic [31:0] ed; logic mis; logic ill; int lat;
  } vec_t;
  vec_t v [17];

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal), .dmem_wr_en(dmem_wr_en),
    .dmem_rw_mode(dmem_rw_mode), .dmem_addr(dmem_addr), .dmem_w_data(dmem_w_data),
    .dmem_r_data(dmem_r_data)
  );

  always #5 clk = ~clk;

  // memory returns the word at addr so bytes above the access size carry neighbour data
  always @(posedge clk) begin
    if (dmem_wr_en) begin
      mem[dmem_addr] <= dmem_w_data[7:0];
      if (dmem_rw_mode != 2'b10) mem[dmem_addr + 12'd1] <= dmem_w_data[15:8];
      if (dmem_rw_mode == 2'b00) begin
        mem[dmem_addr + 12'd2] <= dmem_w_data[23:16];
        mem[dmem_addr + 12'd3] <= dmem_w_data[31:24];
      end
    end
    dmem_r_data <= {mem[dmem_addr + 12'd3], mem[dmem_addr + 12'd2], mem[dmem_addr + 12'd1], mem[dmem_addr]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, cur, act, exp);
    end
  endtask

  task automatic wait_resp(output int lat);
    logic seen = 0;
    lat = 0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) seen = 1;
    end
    chk("resp_seen", 32'(seen), 32'd1);
  endtask

  task automatic run(input vec_t t);
    int lat = 0, wr = 0;
    logic seen = 0;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_store = t.st; req_funct3 = t.f3; req_addr = t.addr; req_wdata = t.wd; req_rd = t.rd;
    @(posedge clk);
    #1 req_valid = 0;
    req_wdata = 32'h5A5A5A5A; req_rd = 5'd31; req_addr = 12'hFFF;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (dmem_wr_en) begin
        wr++;
        chk("wr_mode", 32'(dmem_rw_mode), t.f3 == 3'd0 ? 32'd2 : t.f3 == 3'd1 ? 32'd1 : 32'd0);
        chk("wr_addr", 32'(dmem_addr), 32'(t.addr));
      end
      if (resp_valid) seen = 1;
    end
    chk("resp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(t.lat));
    chk("resp_data", resp_data, t.ed);
    chk("resp_rd", 32'(resp_rd), 32'(t.rd));
    chk("misaligned", 32'(resp_misaligned), 32'(t.mis));
    chk("illegal", 32'(resp_illegal), 32'(t.ill));
    chk("wr_cycles", 32'(wr), t.lat == 2 ? 32'd1 : 32'd0);
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
  endtask

  initial begin
    int lat;
    v[0]  = '{1'b1, 3'd2, 12'd8, 32'h211E1B18, 5'd1,  32'h00000000, 1'b0, 1'b0, 2};
    v[1]  = '{1'b1, 3'd1, 12'd6, 32'hABCD9812, 5'd2,  32'h00000000, 1'b0, 1'b0, 2};
    v[2]  = '{1'b1, 3'd0, 12'd5, 32'h0000000F, 5'd3,  32'h00000000, 1'b0, 1'b0, 2};
    v[3]  = '{1'b0, 3'd0, 12'd5, 32'h0,        5'd4,  32'h0000000F, 1'b0, 1'b0, 3};
    v[4]  = '{1'b1, 3'd0, 12'd5, 32'h00000080, 5'd5,  32'h00000000, 1'b0, 1'b0, 2};
    v[5]  = '{1'b0, 3'd0, 12'd5, 32'h0,        5'd6,  32'hFFFFFF80, 1'b0, 1'b0, 3};
    v[6]  = '{1'b0, 3'd4, 12'd5, 32'h0,        5'd7,  32'h00000080, 1'b0, 1'b0, 3};
    v[7]  = '{1'b0, 3'd1, 12'd6, 32'h0,        5'd8,  32'hFFFF9812, 1'b0, 1'b0, 3};
    v[8]  = '{1'b0, 3'd5, 12'd6, 32'h0,        5'd9,  32'h00009812, 1'b0, 1'b0, 3};
    v[9]  = '{1'b0, 3'd2, 12'd8, 32'h0,        5'd10, 32'h211E1B18, 1'b0, 1'b0, 3};
    v[10] = '{1'b0, 3'd2, 12'd6, 32'h0,        5'd11, 32'h00000000, 1'b1, 1'b0, 1};
    v[11] = '{1'b1, 3'd1, 12'd7, 32'h00001234, 5'd12, 32'h00000000, 1'b1, 1'b0, 1};
    v[12] = '{1'b0, 3'd3, 12'd8, 32'h0,        5'd13, 32'h00000000, 1'b0, 1'b1, 1};
    v[13] = '{1'b1, 3'd3, 12'd7, 32'h11111111, 5'd14, 32'h00000000, 1'b0, 1'b1, 1};
    v[14] = '{1'b1, 3'd4, 12'd1, 32'h22222222, 5'd15, 32'h00000000, 1'b0, 1'b1, 1};
    v[15] = '{1'b0, 3'd6, 12'd3, 32'h0,        5'd16, 32'h00000000, 1'b0, 1'b1, 1};
    v[16] = '{1'b0, 3'd1, 12'd9, 32'h0,        5'd17, 32'h00000000, 1'b1, 1'b0, 1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    rst = 0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wr_en", 32'(dmem_wr_en), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_rd", 32'(resp_rd), 32'd0);
    chk("rst_flags", {30'd0, resp_misaligned, resp_illegal}, 32'd0);
    chk("rst_dmem", {18'd0, dmem_rw_mode, dmem_addr}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      cur = i;
      run(v[i]);
    end
    // backpressure: a second request waits behind a stalled LW response
    cur = 100;
    @(negedge clk);
    req_valid = 1; req_store = 0; req_funct3 = 3'd2; req_addr = 12'd8; req_rd = 5'd20;
    @(posedge clk);
    #1 req_funct3 = 3'd0; req_addr = 12'd5; req_rd = 5'd21;
    wait_resp(lat);
    chk("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", resp_data, 32'h211E1B18);
      chk("bp_rd", 32'(resp_rd), 32'd20);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_valid_drop", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 0;
    chk("bp_accepted", 32'(req_ready), 32'd0);
    wait_resp(lat);
    chk("bp2_latency", 32'(lat), 32'd3);
    chk("bp2_data", resp_data, 32'hFFFFFF80);
    chk("bp2_rd", 32'(resp_rd), 32'd21);
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    // reset during the ACCESS cycle of a store
    cur = 200;
    @(negedge clk);
    req_valid = 1; req_store = 1; req_funct3 = 3'd2; req_addr = 12'd8; req_wdata = 32'hDEADBEEF; req_rd = 5'd22;
    @(posedge clk);
    #1 req_valid = 0;
    chk("mid_wr_en_before", 32'(dmem_wr_en), 32'd1);
    #2 rst = 1;
    #1;
    chk("mid_wr_en_drop", 32'(dmem_wr_en), 32'd0);
    chk("mid_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    cur = 201;
    run('{1'b0, 3'd2, 12'd8, 32'h0, 5'd23, 32'h211E1B18, 1'b0, 1'b0, 3});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
